// File: rtl/ldst_pkg.sv
// Shared types for the load/store arbiter: request/response packets and
// field widths used by the arbiter and its requesters.
package ldst_pkg;

  localparam int LDST_ADDR_W = 32;
  localparam int LDST_DATA_W = 32;
  localparam int LDST_STRB_W = 4;

  typedef struct packed {
    logic [LDST_ADDR_W-1:0] addr;
    logic                   st;
    logic [LDST_DATA_W-1:0] data;
    logic [LDST_STRB_W-1:0] strobe;
  } ldst_req_pkt_t;

  typedef struct packed {
    logic [LDST_DATA_W-1:0] data;
  } ldst_rsp_pkt_t;

endpackage

// File: rtl/ldst_arb_ord_fifo.sv
// Order FIFO: remembers which requester owns each outstanding downstream
// request so in-order responses can be routed back. DEPTH is a power of 2,
// so the pointers wrap by plain overflow.
module ldst_arb_ord_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] cnt
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign cnt     = cnt_q;

  // Pointer and occupancy update; push+pop together leaves cnt unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage; contents are meaningless while empty so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ldst_arbiter.sv
// Load/store port arbiter: N_MST requesters share one downstream memory port.
// Requests pass through combinationally; responses return in order and are
// routed via the order FIFO. A stalled request locks the grant so the
// downstream sees a stable payload. Define LDST_ARB_RR_EN for round-robin
// arbitration; otherwise the lowest requester index wins.
module ldst_arbiter
  import ldst_pkg::*;
#(
  parameter int N_MST     = 2,
  parameter int OST_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_MST-1:0]             m_req_vld,
  output logic [N_MST-1:0]             m_req_rdy,
  input  logic [N_MST*LDST_ADDR_W-1:0] m_req_addr,
  input  logic [N_MST-1:0]             m_req_st,
  input  logic [N_MST*LDST_DATA_W-1:0] m_req_data,
  input  logic [N_MST*LDST_STRB_W-1:0] m_req_strobe,
  output logic [N_MST-1:0]             m_rsp_vld,
  input  logic [N_MST-1:0]             m_rsp_rdy,
  output logic [LDST_DATA_W-1:0]       m_rsp_data,
  output logic                         s_req_vld,
  input  logic                         s_req_rdy,
  output logic [LDST_ADDR_W-1:0]       s_req_addr,
  output logic                         s_req_st,
  output logic [LDST_DATA_W-1:0]       s_req_data,
  output logic [LDST_STRB_W-1:0]       s_req_strobe,
  input  logic                         s_rsp_vld,
  output logic                         s_rsp_rdy,
  input  logic [LDST_DATA_W-1:0]       s_rsp_data,
  output logic [$clog2(OST_DEPTH):0]   ost_cnt
);

  localparam int ID_W = $clog2(N_MST);

  ldst_req_pkt_t   req_arr [N_MST];
  ldst_req_pkt_t   s_req;
  ldst_rsp_pkt_t   rsp;
  logic [ID_W-1:0] win, grant, head;
  logic            lock_q, lock_d;
  logic [ID_W-1:0] lock_id_q, lock_id_d;
  logic            full, empty;
  logic            req_hs, rsp_hs;

  // Unpack each requester's flat port slices into a request packet.
  for (genvar g = 0; g < N_MST; g++) begin : g_slice
    assign req_arr[g] = '{addr:   m_req_addr[g*LDST_ADDR_W +: LDST_ADDR_W],
                          st:     m_req_st[g],
                          data:   m_req_data[g*LDST_DATA_W +: LDST_DATA_W],
                          strobe: m_req_strobe[g*LDST_STRB_W +: LDST_STRB_W]};
  end

`ifdef LDST_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  // Round-robin pick: scan from rr_ptr upward with wrap; the downward loop
  // lets the requester nearest rr_ptr overwrite the others.
  always_comb begin
    int j;
    j   = 0;
    win = rr_ptr_q;
    for (int k = N_MST-1; k >= 0; k--) begin
      j = int'(rr_ptr_q) + k;
      if (j >= N_MST) j = j - N_MST;
      if (m_req_vld[j]) win = ID_W'(j);
    end
  end

  // Next search starts just after the requester that was served.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (req_hs) rr_ptr_d = (grant == ID_W'(N_MST-1)) ? '0 : grant + ID_W'(1);
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  // Fixed priority pick: lowest valid index wins.
  always_comb begin
    win = '0;
    for (int k = N_MST-1; k >= 0; k--) begin
      if (m_req_vld[k]) win = ID_W'(k);
    end
  end
`endif

  assign grant     = lock_q ? lock_id_q : win;
  assign s_req     = req_arr[grant];
  assign s_req_vld = (|m_req_vld) & ~full;
  assign req_hs    = s_req_vld & s_req_rdy;
  assign rsp_hs    = s_rsp_vld & s_rsp_rdy;

  assign s_req_addr   = s_req.addr;
  assign s_req_st     = s_req.st;
  assign s_req_data   = s_req.data;
  assign s_req_strobe = s_req.strobe;

  // Only the granted requester sees ready.
  always_comb begin
    m_req_rdy        = '0;
    m_req_rdy[grant] = s_req_rdy & ~full;
  end

  // Hold the grant while the downstream stalls an offered request.
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (req_hs) begin
      lock_d = 1'b0;
    end else if (s_req_vld) begin
      lock_d    = 1'b1;
      lock_id_d = grant;
    end
  end

  // Lock state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  ldst_arb_ord_fifo #(
    .DEPTH (OST_DEPTH),
    .W     (ID_W)
  ) u_ord_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_hs),
    .pop   (rsp_hs),
    .din   (grant),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .cnt   (ost_cnt)
  );

  // Route the response to the FIFO head; nothing is accepted while empty.
  always_comb begin
    m_rsp_vld       = '0;
    m_rsp_vld[head] = s_rsp_vld & ~empty;
    s_rsp_rdy       = m_rsp_rdy[head] & ~empty;
  end

  assign rsp.data   = s_rsp_data;
  assign m_rsp_data = rsp.data;

endmodule

// File: tb/tb_ldst_arbiter.sv
// Scoreboard bench for ldst_arbiter: randomized requesters and downstream
// slave, a spec-level reference model of grant/lock/occupancy, and an
// expected-response queue checked as responses are delivered.
`timescale 1ns/1ps
module tb_ldst_arbiter;
  import ldst_pkg::*;

  localparam int N     = 2;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      m_req_vld, m_req_rdy, m_req_st, m_rsp_vld, m_rsp_rdy;
  logic [N*32-1:0]   m_req_addr, m_req_data;
  logic [N*4-1:0]    m_req_strobe;
  logic [31:0]       m_rsp_data, s_req_addr, s_req_data, s_rsp_data;
  logic              s_req_vld, s_req_rdy, s_req_st, s_rsp_vld, s_rsp_rdy;
  logic [3:0]        s_req_strobe;
  logic [CW-1:0]     ost_cnt;

  always #5 clk = ~clk;

  ldst_arbiter #(.N_MST(N), .OST_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_vld(m_req_vld), .m_req_rdy(m_req_rdy), .m_req_addr(m_req_addr),
    .m_req_st(m_req_st), .m_req_data(m_req_data), .m_req_strobe(m_req_strobe),
    .m_rsp_vld(m_rsp_vld), .m_rsp_rdy(m_rsp_rdy), .m_rsp_data(m_rsp_data),
    .s_req_vld(s_req_vld), .s_req_rdy(s_req_rdy), .s_req_addr(s_req_addr),
    .s_req_st(s_req_st), .s_req_data(s_req_data), .s_req_strobe(s_req_strobe),
    .s_rsp_vld(s_rsp_vld), .s_rsp_rdy(s_rsp_rdy), .s_rsp_data(s_rsp_data),
    .ost_cnt(ost_cnt)
  );

  typedef struct { int id; logic [31:0] data; } exp_t;

  exp_t          exp_q[$];
  exp_t          rsp_log[$];
  int            grant_log[$];
  ldst_req_pkt_t req_q [N][$];
  bit            present [N];
  logic [31:0]   slv_q[$];
  bit            slv_pres;
  logic [31:0]   ovr [logic [31:0]];
  int            p_issue, p_srdy, p_srsp, p_mrdy;
  int            n_chk, n_fail;
  int            cnt_m, lock_id_m, rr_m;
  bit            lock_m;

  function automatic logic [31:0] rsp_of(logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic int onehot_idx(logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  // Expected winner from the arbitration rule, ignoring lock.
  function automatic int winner();
`ifdef LDST_ARB_RR_EN
    for (int k = 0; k < N; k++) if (m_req_vld[(rr_m + k) % N]) return (rr_m + k) % N;
    return rr_m;
`else
    for (int k = 0; k < N; k++) if (m_req_vld[k]) return k;
    return 0;
`endif
  endfunction

  function automatic bit busy();
    int s = 0;
    for (int i = 0; i < N; i++) s += req_q[i].size() + int'(present[i]);
    return (s != 0) || (cnt_m != 0) || (slv_q.size() != 0);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(int maxc);
    int c = 0;
    while (busy() && c < maxc) begin
      @(negedge clk);
      c++;
    end
    #1;
    chk("idle_timeout", c >= maxc, 0);
  endtask

  task automatic enq(int i, logic [31:0] a, logic st);
    ldst_req_pkt_t p;
    p.addr   = a;
    p.st     = st;
    p.data   = $urandom;
    p.strobe = 4'($urandom);
    req_q[i].push_back(p);
  endtask

  // Requesters: raise vld when a request is queued, hold it until accepted.
  task automatic drv();
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (m_req_vld[i] && m_req_rdy[i]) begin
          req_q[i].delete(0);
          present[i] = 1'b0;
        end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!present[i] && req_q[i].size() > 0 && $urandom_range(0, 99) < p_issue)
          present[i] = 1'b1;
        m_req_vld[i] = present[i];
        if (present[i]) begin
          m_req_addr[i*32 +: 32]  = req_q[i][0].addr;
          m_req_st[i]             = req_q[i][0].st;
          m_req_data[i*32 +: 32]  = req_q[i][0].data;
          m_req_strobe[i*4 +: 4]  = req_q[i][0].strobe;
        end
        m_rsp_rdy[i] = ($urandom_range(0, 99) < p_mrdy);
      end
    end
  endtask

  // Downstream slave: accepts requests, answers in order.
  task automatic slv();
    forever begin
      @(negedge clk);
      if (s_req_vld && s_req_rdy) slv_q.push_back(rsp_of(s_req_addr));
      if (s_rsp_vld && s_rsp_rdy) begin
        slv_q.delete(0);
        slv_pres = 1'b0;
      end
      @(posedge clk);
      #1;
      s_req_rdy = ($urandom_range(0, 99) < p_srdy);
      if (!slv_pres && slv_q.size() > 0 && $urandom_range(0, 99) < p_srsp) slv_pres = 1'b1;
      s_rsp_vld  = slv_pres;
      s_rsp_data = slv_pres ? slv_q[0] : 32'h0;
    end
  endtask

  // Monitor/scoreboard: compares every cycle against the reference model.
  task automatic mon();
    forever begin
      int g, h;
      bit any, full_m, esv;
      logic [N-1:0] erdy, ersp;
      @(negedge clk);
      any    = |m_req_vld;
      full_m = (cnt_m == DEPTH);
      g      = lock_m ? lock_id_m : winner();
      esv    = any && !full_m;
      chk("s_req_vld", s_req_vld, esv);
      if (any || !s_req_rdy || full_m) begin
        erdy = (s_req_rdy && !full_m) ? N'(1) << g : '0;
        chk("m_req_rdy", m_req_rdy, erdy);
      end
      if (esv) begin
        chk("s_req_addr", s_req_addr, m_req_addr[g*32 +: 32]);
        chk("s_req_st", s_req_st, m_req_st[g]);
        chk("s_req_data", s_req_data, m_req_data[g*32 +: 32]);
        chk("s_req_strobe", s_req_strobe, m_req_strobe[g*4 +: 4]);
      end
      chk("ost_cnt", ost_cnt, cnt_m);
      if (lock_m) chk("lock_hold", m_req_vld[lock_id_m], 1);
      if (exp_q.size() == 0) begin
        chk("rsp_when_empty", s_rsp_vld, 0);
        chk("m_rsp_vld_empty", m_rsp_vld, 0);
        chk("s_rsp_rdy_empty", s_rsp_rdy, 0);
      end else begin
        h    = exp_q[0].id;
        ersp = s_rsp_vld ? N'(1) << h : '0;
        chk("m_rsp_vld", m_rsp_vld, ersp);
        chk("s_rsp_rdy", s_rsp_rdy, m_rsp_rdy[h]);
        if (s_rsp_vld && m_rsp_rdy[h]) begin
          chk("rsp_data", m_rsp_data, exp_q[0].data);
          rsp_log.push_back('{id: onehot_idx(m_rsp_vld), data: m_rsp_data});
          exp_q.delete(0);
          cnt_m--;
        end
      end
      if (esv && s_req_rdy) begin
        exp_q.push_back('{id: g, data: rsp_of(m_req_addr[g*32 +: 32])});
        grant_log.push_back(onehot_idx(m_req_rdy));
        cnt_m++;
        lock_m = 1'b0;
        rr_m   = (g + 1) % N;
      end else if (esv) begin
        lock_m    = 1'b1;
        lock_id_m = g;
      end
    end
  endtask

  initial begin
    int exp2 [4];
    int nreq;
    m_req_vld = '0; m_req_addr = '0; m_req_st = '0; m_req_data = '0;
    m_req_strobe = '0; m_rsp_rdy = '0; s_req_rdy = 1'b0; s_rsp_vld = 1'b0;
    s_rsp_data = '0;
    n_chk = 0; n_fail = 0; cnt_m = 0; lock_m = 0; lock_id_m = 0; rr_m = 0;
    p_issue = 0; p_srdy = 0; p_srsp = 0; p_mrdy = 0; slv_pres = 0;
    for (int i = 0; i < N; i++) present[i] = 1'b0;

    // Reset state
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    chk("rst_ost_cnt", ost_cnt, 0);
    chk("rst_s_req_vld", s_req_vld, 0);
    chk("rst_m_req_rdy", m_req_rdy, 0);
    chk("rst_m_rsp_vld", m_rsp_vld, 0);
    chk("rst_s_rsp_rdy", s_rsp_rdy, 0);

    fork
      drv();
      slv();
      mon();
    join_none

    // Contention: both requesters always valid
    p_issue = 100; p_srdy = 100; p_srsp = 100; p_mrdy = 100;
    for (int k = 0; k < 4; k++) begin
      enq(0, 32'h0000_0010 + 32'(k*4), 1'b0);
      enq(1, 32'h0000_0050 + 32'(k*4), 1'b1);
    end
    wait_idle(200);
`ifdef LDST_ARB_RR_EN
    exp2 = '{0, 1, 0, 1};
`else
    exp2 = '{0, 0, 0, 0};
`endif
    chk("cont_len", grant_log.size() >= 4, 1);
    if (grant_log.size() >= 4)
      for (int k = 0; k < 4; k++) chk("cont_grant", grant_log[k], exp2[k]);

    // Single load, response three cycles later
    grant_log.delete(); rsp_log.delete();
    ovr[32'h100] = 32'hDEAD_BEEF;
    p_srsp = 0;
    enq(0, 32'h100, 1'b0);
    cyc(4);
    chk("single_ost", ost_cnt, 1);
    p_srsp = 100;
    wait_idle(100);
    chk("single_len", rsp_log.size(), 1);
    if (rsp_log.size() == 1) begin
      chk("single_id", rsp_log[0].id, 0);
      chk("single_data", rsp_log[0].data, 32'hDEAD_BEEF);
    end
    chk("single_ost_end", ost_cnt, 0);

    // Lock: requester 1 stalled, requester 0 arrives, grant must hold
    grant_log.delete();
    p_srdy = 0;
    enq(1, 32'h0000_0700, 1'b1);
    cyc(1);
    enq(0, 32'h0000_0600, 1'b0);
    cyc(1);
    chk("lock_addr", s_req_addr, 32'h0000_0700);
    p_srdy = 100;
    wait_idle(100);
    chk("lock_len", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("lock_first", grant_log[0], 1);
      chk("lock_second", grant_log[1], 0);
    end

    // Full: four outstanding, fifth stalls until one response
    p_srsp = 0;
    for (int k = 0; k < 5; k++) enq(0, 32'h0000_0300 + 32'(k*4), 1'b0);
    cyc(8);
    chk("full_ost", ost_cnt, 4);
    chk("full_s_req_vld", s_req_vld, 0);
    chk("full_m_req_rdy", m_req_rdy, 0);
    p_srsp = 100;
    cyc(1);
    p_srsp = 0;
    cyc(1);
    chk("resume_ost", ost_cnt, 3);
    chk("resume_s_req_vld", s_req_vld, 1);
    chk("resume_m_req_rdy", m_req_rdy, 2'b01);
    p_srsp = 100;
    wait_idle(100);

    // Ordering: IDs 0,1,1,0 get responses A,B,C,D
    p_srsp = 0;
    for (int k = 0; k < 4; k++) ovr[32'h200 + 32'(k)] = 32'hA + 32'(k);
    enq(0, 32'h200, 1'b0); cyc(3);
    enq(1, 32'h201, 1'b0); cyc(3);
    enq(1, 32'h202, 1'b0); cyc(3);
    enq(0, 32'h203, 1'b0); cyc(3);
    chk("ord_ost", ost_cnt, 4);
    rsp_log.delete();
    p_srsp = 100;
    wait_idle(100);
    chk("ord_len", rsp_log.size(), 4);
    if (rsp_log.size() == 4) begin
      chk("ord_id0", rsp_log[0].id, 0); chk("ord_d0", rsp_log[0].data, 32'hA);
      chk("ord_id1", rsp_log[1].id, 1); chk("ord_d1", rsp_log[1].data, 32'hB);
      chk("ord_id2", rsp_log[2].id, 1); chk("ord_d2", rsp_log[2].data, 32'hC);
      chk("ord_id3", rsp_log[3].id, 0); chk("ord_d3", rsp_log[3].data, 32'hD);
    end

    // Push and pop in the same cycle at ost_cnt = 2, then response backpressure
    p_srsp = 0;
    enq(0, 32'h400, 1'b0);
    enq(1, 32'h404, 1'b1);
    cyc(4);
    chk("pp_pre", ost_cnt, 2);
    rsp_log.delete(); grant_log.delete();
    enq(0, 32'h408, 1'b0);
    p_srsp = 100;
    cyc(1);
    p_srsp = 0;
    cyc(1);
    chk("pp_ost", ost_cnt, 2);
    chk("pp_rsp", rsp_log.size(), 1);
    chk("pp_req", grant_log.size(), 1);
    p_mrdy = 0;
    p_srsp = 100;
    cyc(3);
    chk("bp_s_rsp_vld", s_rsp_vld, 1);
    chk("bp_s_rsp_rdy", s_rsp_rdy, 0);
    chk("bp_ost", ost_cnt, 2);
    p_mrdy = 100;
    wait_idle(100);

    // Randomized traffic
    nreq = 0;
    while (nreq < 300) begin
      if (nreq % 20 == 0) begin
        p_issue = int'($urandom_range(30, 100));
        p_srdy  = int'($urandom_range(20, 100));
        p_srsp  = int'($urandom_range(20, 100));
        p_mrdy  = int'($urandom_range(20, 100));
      end
      enq(int'($urandom_range(0, N-1)), $urandom | 32'h0001_0000, 1'($urandom));
      nreq++;
      cyc(int'($urandom_range(0, 3)));
    end
    wait_idle(20000);
    chk("final_exp_q", exp_q.size(), 0);
    chk("final_ost", ost_cnt, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
